// File: rtl/max7219_mon_pkg.sv
// Shared register map, word layout and FSM encoding for the MAX7219 bus monitor.
package max7219_mon_pkg;

   localparam int WORD_W = 16;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
   localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
   localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
   localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
   localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
   localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
   localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } mon_state_e;

   // Low 12 bits of a bus word; the top nibble is don't-care on the MAX7219.
   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } max_word_t;

endpackage

// File: rtl/max7219_mon_sync.sv
// Synchronizes the asynchronous MAX7219 bus pins and derives cs/sclk edge strobes
// with din delayed to line up with the sclk rising strobe.
module max7219_mon_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic max_cs,
   input  logic max_sclk,
   input  logic max_din,
   output logic cs_o,
   output logic cs_fall_o,
   output logic cs_rise_o,
   output logic sclk_rise_o,
   output logic din_o
);

   logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
   logic                   cs_edge_q, sclk_edge_q, din_edge_q;

   // NOTE: the synchronizers carry no reset so they keep tracking the bus through rst;
   // a reset in mid-frame therefore never fabricates a cs falling edge on release.
   always_ff @(posedge clk) begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], max_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], max_sclk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], max_din};
      cs_edge_q   <= cs_sync_q[SYNC_STAGES-1];
      sclk_edge_q <= sclk_sync_q[SYNC_STAGES-1];
      din_edge_q  <= din_sync_q[SYNC_STAGES-1];
   end

   assign cs_o        = cs_sync_q[SYNC_STAGES-1];
   assign cs_fall_o   = cs_edge_q & ~cs_sync_q[SYNC_STAGES-1];
   assign cs_rise_o   = ~cs_edge_q & cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise_o = ~sclk_edge_q & sclk_sync_q[SYNC_STAGES-1];
   assign din_o       = din_edge_q;

endmodule

// File: rtl/max7219_frame_monitor.sv
// Passive MAX7219 cascade snooper with a shadow framebuffer and registered read port.
// Optional: define MAX7219_MON_SCAN_LIMIT_EN to blank rows beyond each device's scan limit.
module max7219_frame_monitor
   import max7219_mon_pkg::*;
#(
   parameter int NUM_DEVICES = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           max_cs,
   input  logic                           max_sclk,
   input  logic                           max_din,
   input  logic [$clog2(NUM_DEVICES)-1:0] rd_dev,
   input  logic [2:0]                     rd_row,
   output logic [7:0]                     rd_data,
   output logic [NUM_DEVICES-1:0]         disp_on,
   output logic [NUM_DEVICES-1:0]         disp_test,
   output logic                           frame_stb,
   output logic                           frame_err,
   output logic [15:0]                    frame_cnt
);

   localparam int FRAME_W = WORD_W * NUM_DEVICES;
   localparam int CNT_W   = $clog2(FRAME_W + 2);
   localparam int IDX_W   = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

   logic cs_lvl, cs_fall, cs_rise, sclk_rise, din_s;

   max7219_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .max_cs     (max_cs),
      .max_sclk   (max_sclk),
      .max_din    (max_din),
      .cs_o       (cs_lvl),
      .cs_fall_o  (cs_fall),
      .cs_rise_o  (cs_rise),
      .sclk_rise_o(sclk_rise),
      .din_o      (din_s)
   );

   mon_state_e              state_q, state_d;
   logic [CNT_W-1:0]        bit_cnt_q;
   logic [FRAME_W-1:0]      shift_q, commit_q;
   logic [IDX_W-1:0]        dev_idx_q;
   logic [7:0]              fb_q [NUM_DEVICES][8];
   logic [7:0]              rd_data_q;
   logic [NUM_DEVICES-1:0]  disp_on_q, disp_test_q;
   logic                    frame_stb_q, frame_err_q;
   logic [15:0]             frame_cnt_q;
   logic                    commit_ld, len_err, ovr_err, last_dev, rd_hit;
   max_word_t               word;
`ifdef MAX7219_MON_SCAN_LIMIT_EN
   logic [2:0]              scan_limit_q [NUM_DEVICES];
`endif

   assign word = max_word_t'(commit_q[{dev_idx_q, 4'h0} +: $bits(max_word_t)]);

   always_comb begin
      state_d   = state_q;
      commit_ld = 1'b0;
      len_err   = 1'b0;
      ovr_err   = 1'b0;
      last_dev  = 1'b0;
      unique case (state_q)
         ST_IDLE: if (cs_fall) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
               if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                  commit_ld = 1'b1;
                  state_d   = ST_COMMIT;
               end else if (bit_cnt_q != '0) begin
                  len_err = 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            // A frame closing while the previous one is still being decoded is lost.
            ovr_err = cs_rise;
            if (dev_idx_q == IDX_W'(NUM_DEVICES - 1)) begin
               last_dev = 1'b1;
               state_d  = cs_lvl ? ST_IDLE : ST_SHIFT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Shift path runs independently of the FSM so a new frame can arrive during COMMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q <= '0;
      end else if (cs_fall) begin
         bit_cnt_q <= '0;
      end else if (sclk_rise && !cs_lvl && bit_cnt_q != CNT_W'(FRAME_W + 1)) begin
         bit_cnt_q <= bit_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (sclk_rise && !cs_lvl) shift_q <= {shift_q[FRAME_W-2:0], din_s};
      if (commit_ld)            commit_q <= shift_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dev_idx_q   <= '0;
         disp_on_q   <= '0;
         disp_test_q <= '0;
         frame_stb_q <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
         for (int d = 0; d < NUM_DEVICES; d++) begin
            for (int r = 0; r < 8; r++) fb_q[d][r] <= '0;
`ifdef MAX7219_MON_SCAN_LIMIT_EN
            scan_limit_q[d] <= 3'd7;
`endif
         end
      end else begin
         frame_stb_q <= last_dev;
         frame_err_q <= frame_err_q | len_err | ovr_err;
         if (last_dev) frame_cnt_q <= frame_cnt_q + 16'd1;
         dev_idx_q <= (state_q == ST_COMMIT && !last_dev) ? dev_idx_q + 1'b1 : '0;
         if (state_q == ST_COMMIT) begin
            case (word.addr)
               ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
               ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                  fb_q[dev_idx_q][word.addr[2:0] - 3'd1] <= word.data;
               ADDR_SHUTDOWN: disp_on_q[dev_idx_q]   <= word.data[0];
               ADDR_TEST:     disp_test_q[dev_idx_q] <= word.data[0];
`ifdef MAX7219_MON_SCAN_LIMIT_EN
               ADDR_SCANLIMIT: scan_limit_q[dev_idx_q] <= word.data[2:0];
`else
               ADDR_SCANLIMIT: ;
`endif
               ADDR_NOOP, ADDR_DECODE, ADDR_INTENSITY: ;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_hit = 1'b0;
      if (int'(rd_dev) < NUM_DEVICES) begin
         rd_hit = 1'b1;
`ifdef MAX7219_MON_SCAN_LIMIT_EN
         if (rd_row > scan_limit_q[rd_dev]) rd_hit = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         rd_data_q <= '0;
      else if (rd_hit) rd_data_q <= fb_q[rd_dev][rd_row];
      else             rd_data_q <= '0;
   end

   assign rd_data   = rd_data_q;
   assign disp_on   = disp_on_q;
   assign disp_test = disp_test_q;
   assign frame_stb = frame_stb_q;
   assign frame_err = frame_err_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_max7219_frame_monitor.sv
// Self-checking bench: drives MAX7219 bus frames and compares against a framebuffer model.
module tb_max7219_frame_monitor;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       max_cs = 1'b1;
   logic       max_sclk = 1'b0;
   logic       max_din = 1'b0;
   logic [1:0] rd_dev = '0;
   logic [2:0] rd_row = '0;
   logic [7:0] rd_data;
   logic [N-1:0] disp_on, disp_test;
   logic       frame_stb, frame_err;
   logic [15:0] frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int stb_seen = 0;
   int stb_exp = 0;

   logic [7:0]   fb_m [N][8];
   logic [2:0]   scan_m [N];
   logic [N-1:0] on_m, test_m;
   logic [15:0]  cnt_m;
   logic         err_m;

   max7219_frame_monitor #(.NUM_DEVICES(N), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .max_cs(max_cs), .max_sclk(max_sclk), .max_din(max_din),
      .rd_dev(rd_dev), .rd_row(rd_row), .rd_data(rd_data), .disp_on(disp_on),
      .disp_test(disp_test), .frame_stb(frame_stb), .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_stb === 1'b1) stb_seen++;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int d = 0; d < N; d++) begin
         for (int r = 0; r < 8; r++) fb_m[d][r] = '0;
         scan_m[d] = 3'd7;
      end
      on_m = '0; test_m = '0; cnt_m = '0; err_m = 1'b0;
   endtask

   // Frame word d occupies bits [16d+15:16d]; the word sent first lands in the farthest device.
   task automatic model_commit(input logic [63:0] f);
      for (int d = 0; d < N; d++) begin
         logic [15:0] w;
         w = f[16*d +: 16];
         if (w[11:8] >= 4'h1 && w[11:8] <= 4'h8) fb_m[d][w[11:8] - 4'h1] = w[7:0];
         else if (w[11:8] == 4'hC) on_m[d] = w[0];
         else if (w[11:8] == 4'hF) test_m[d] = w[0];
         else if (w[11:8] == 4'hB) scan_m[d] = w[2:0];
      end
      cnt_m = cnt_m + 16'd1;
      stb_exp++;
   endtask

   function automatic logic [7:0] exp_cell(input int d, input int r);
`ifdef MAX7219_MON_SCAN_LIMIT_EN
      if (r > int'(scan_m[d])) return 8'h00;
`endif
      return fb_m[d][r];
   endfunction

   task automatic shift_bits(input logic [63:0] f, input int from, input int cnt);
      for (int i = from; i < from + cnt; i++) begin
         max_din = f[63-i];
         clks(3);
         max_sclk = 1'b1;
         clks(3);
         max_sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [63:0] f, input int nbits, input int gap);
      max_cs = 1'b0;
      clks(3);
      shift_bits(f, 0, nbits);
      clks(3);
      max_cs = 1'b1;
      clks(gap);
      if (nbits == 64) model_commit(f);
      else if (nbits != 0) err_m = 1'b1;
   endtask

   function automatic logic [63:0] all_words(input logic [15:0] w);
      return {w, w, w, w};
   endfunction

   task automatic check_status(input string tag);
      n_vec++;
      if (frame_cnt !== cnt_m) begin
         n_err++; $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, cnt_m);
      end
      n_vec++;
      if (frame_err !== err_m) begin
         n_err++; $display("FAIL %s frame_err: got %b want %b", tag, frame_err, err_m);
      end
      n_vec++;
      if (disp_on !== on_m) begin
         n_err++; $display("FAIL %s disp_on: got %b want %b", tag, disp_on, on_m);
      end
      n_vec++;
      if (disp_test !== test_m) begin
         n_err++; $display("FAIL %s disp_test: got %b want %b", tag, disp_test, test_m);
      end
      n_vec++;
      if (stb_seen !== stb_exp) begin
         n_err++; $display("FAIL %s frame_stb pulses: got %0d want %0d", tag, stb_seen, stb_exp);
      end
   endtask

   task automatic read_cell(input int d, input int r, output logic [7:0] v);
      rd_dev = 2'(d);
      rd_row = 3'(r);
      clks(1);
      v = rd_data;
   endtask

   task automatic check_cell(input string tag, input int d, input int r, input logic [7:0] want);
      logic [7:0] v;
      read_cell(d, r, v);
      n_vec++;
      if (v !== want) begin
         n_err++; $display("FAIL %s rd_data[%0d][%0d]: got %02h want %02h", tag, d, r, v, want);
      end
   endtask

   task automatic check_reads(input string tag);
      for (int d = 0; d < N; d++)
         for (int r = 0; r < 8; r++) check_cell(tag, d, r, exp_cell(d, r));
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      clks(6);
      n_vec++;
      if (rd_data !== 8'h00 || frame_stb !== 1'b0) begin
         n_err++; $display("FAIL reset rd_data/stb: got %02h/%b want 00/0", rd_data, frame_stb);
      end
      check_status("reset");
      rst = 1'b0;
      clks(2);
      check_reads("reset");
   endtask

   task automatic test_shutdown();
      send_frame({16'h0C01, 16'h0C01, 16'h0C00, 16'h0C01}, 64, 15);
      n_vec++;
      if (disp_on !== 4'b1101) begin
         n_err++; $display("FAIL shutdown disp_on: got %b want 1101", disp_on);
      end
      n_vec++;
      if (frame_cnt !== 16'd1) begin
         n_err++; $display("FAIL shutdown frame_cnt: got %0d want 1", frame_cnt);
      end
      check_status("shutdown");
   endtask

   task automatic test_digits();
      send_frame(all_words(16'h0355), 64, 15);
      check_cell("digits", 2, 2, 8'h55);
      check_cell("digits", 2, 3, 8'h00);
      check_status("digits");
      check_reads("digits");
   endtask

   task automatic test_glitch();
      max_cs = 1'b1;
      for (int i = 0; i < 16'h0FFF; i++) begin
         max_din = 1'($urandom());
         max_sclk = 1'b1;
         clks(2);
         max_sclk = 1'b0;
         clks(2);
      end
      send_frame('0, 0, 15);
      check_status("glitch");
      check_reads("glitch");
   endtask

   task automatic test_random();
      for (int k = 0; k < 20; k++) begin
         logic [63:0] f;
         int gap;
         f   = {32'($urandom()), 32'($urandom())};
         gap = $urandom_range(3, 16);
         send_frame(f, 64, gap);
         if (gap >= 12) check_status("random");
      end
      clks(15);
      check_status("random_end");
      check_reads("random_end");
   endtask

   task automatic test_short_frame();
      logic [63:0] f;
      send_frame(all_words(16'h01AA), 48, 15);
      check_status("short");
      check_reads("short");
      f = {32'($urandom()), 32'($urandom())};
      send_frame(f, 64, 15);
      check_status("short_then_good");
      check_reads("short_then_good");
   endtask

   task automatic test_reset_mid_frame();
      logic [63:0] f;
      f = all_words(16'h0C01);
      max_cs = 1'b0;
      clks(3);
      shift_bits(f, 0, 30);
      rst = 1'b1;
      clks(3);
      rst = 1'b0;
      model_reset();
      shift_bits(f, 30, 34);
      clks(3);
      max_cs = 1'b1;
      clks(15);
      check_status("rst_mid_abandon");
      send_frame(all_words(16'h0766), 64, 15);
      n_vec++;
      if (frame_cnt !== 16'd1) begin
         n_err++; $display("FAIL rst_mid frame_cnt: got %0d want 1", frame_cnt);
      end
      check_status("rst_mid_good");
      check_reads("rst_mid_good");
   endtask

   task automatic test_overrun();
      logic [63:0] f;
      f = {32'($urandom()), 32'($urandom())};
      max_cs = 1'b0;
      clks(3);
      shift_bits(f, 0, 64);
      clks(3);
      max_cs = 1'b1;
      clks(2);
      max_cs = 1'b0;
      clks(1);
      max_cs = 1'b1;
      clks(15);
      model_commit(f);
      err_m = 1'b1;
      n_vec++;
      if (frame_err !== 1'b1) begin
         n_err++; $display("FAIL overrun frame_err: got %b want 1", frame_err);
      end
      check_status("overrun");
      check_reads("overrun");
   endtask

   task automatic test_scan_limit();
      logic [7:0] row7_want;
`ifdef MAX7219_MON_SCAN_LIMIT_EN
      row7_want = 8'h00;
`else
      row7_want = 8'hFF;
`endif
      rst = 1'b1;
      clks(3);
      rst = 1'b0;
      model_reset();
      clks(2);
      send_frame(all_words(16'h0B03), 64, 15);
      send_frame(all_words(16'h04A5), 64, 15);
      send_frame(all_words(16'h08FF), 64, 15);
      for (int d = 0; d < N; d++) begin
         check_cell("scan_row7", d, 7, row7_want);
         check_cell("scan_row3", d, 3, 8'hA5);
      end
      check_status("scan");
      check_reads("scan");
   endtask

   initial begin
      test_reset();
      test_shutdown();
      test_digits();
      test_glitch();
      test_random();
      test_short_frame();
      test_reset_mid_frame();
      test_overrun();
      test_scan_limit();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
